ste_snd_dma: RTL and testbench

STE DMA sound fetch engine on the MCU side, directly upstream of the shifter's audio FIFO. It holds the frame start, end and current address registers and the play/loop control. It watches the shifter's SREQ, issues one word fetch per granted sound slot, and strobes SLOAD_N so the shifter latches MDIN into its FIFO. At frame end it either stops or reloads from the start address, and it signals frame-end and activity to the interrupt logic.

---
 rtl/ste_snd_dma.sv | 122 ++++++++++++
 tb/tb_ste_snd_dma.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ste_snd_dma.sv
// ste_snd_dma: STE DMA sound fetch engine (frame registers, SREQ/SND_SLOT fetch FSM, loop/stop at frame end); SINT frame-end pulse built only with STE_SND_FRAME_IRQ_EN
module ste_snd_dma #(
  parameter int ADDR_W   = 22,
  parameter int LOAD_LEN = 4
) (
  input  logic              clk32,
  input  logic              resb,
  input  logic              CS,
  input  logic [4:0]        A,
  input  logic              RW,
  input  logic [15:0]       DIN,
  output logic [15:0]       DOUT,
  input  logic              SREQ,
  input  logic              SND_SLOT,
  output logic              SLOAD_N,
  output logic [ADDR_W-2:0] SADDR,
  output logic              SACTIVE,
  output logic              SINT
);
  localparam int LW = $clog2(LOAD_LEN + 1);
  typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;
  state_t state;
  logic cs_d, play, loop_en, we, frame_end, unused;
  logic [ADDR_W-2:0] start, fend, cnt, wend;
  logic [LW-1:0] lcnt;
  logic [23:0] st_b, en_b, ct_b;
  assign we = ~cs_d & CS & ~RW;
  assign frame_end = (state == WAIT) & play & (cnt == wend);
  assign st_b = 24'({start, 1'b0});
  assign en_b = 24'({fend, 1'b0});
  assign ct_b = 24'({cnt, 1'b0});
  assign unused = &{1'b0, DIN[15:8]};
  always_comb begin
    DOUT = '0;
    if (CS & RW)
      case (A)
        5'd0: DOUT = {14'b0, loop_en, play};
        5'd1: DOUT = {8'b0, st_b[23:16]};
        5'd2: DOUT = {8'b0, st_b[15:8]};
        5'd3: DOUT = {8'b0, st_b[7:0]};
        5'd4: DOUT = {8'b0, ct_b[23:16]};
        5'd5: DOUT = {8'b0, ct_b[15:8]};
        5'd6: DOUT = {8'b0, ct_b[7:0]};
        5'd7: DOUT = {8'b0, en_b[23:16]};
        5'd8: DOUT = {8'b0, en_b[15:8]};
        5'd9: DOUT = {8'b0, en_b[7:0]};
        default: DOUT = '0;
      endcase
  end
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state   <= IDLE;
      cs_d    <= 1'b0;
      play    <= 1'b0;
      loop_en <= 1'b0;
      start   <= '0;
      fend    <= '0;
      cnt     <= '0;
      wend    <= '0;
      lcnt    <= '0;
      SADDR   <= '0;
      SLOAD_N <= 1'b1;
      SACTIVE <= 1'b0;
    end else begin
      cs_d <= CS;
      case (state)
        IDLE: if (play) begin
          cnt     <= start;
          wend    <= fend;
          SACTIVE <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (!play) begin
          SACTIVE <= 1'b0;
          state   <= IDLE;
        end else if (frame_end) begin
          if (loop_en) begin
            cnt  <= start;
            wend <= fend;
          end else begin
            play    <= 1'b0;
            SACTIVE <= 1'b0;
            state   <= IDLE;
          end
        end else if (SREQ & SND_SLOT) begin
          SADDR   <= cnt;
          SLOAD_N <= 1'b0;
          lcnt    <= '0;
          state   <= LOAD;
        end
        LOAD: if (lcnt == LW'(LOAD_LEN - 1)) begin
          SLOAD_N <= 1'b1;
          cnt     <= cnt + (ADDR_W-1)'(1);
          state   <= WAIT;
        end else begin
          lcnt <= lcnt + LW'(1);
        end
        default: state <= IDLE;
      endcase
      // CPU writes come last so a control write beats a same-cycle frame-end clear
      if (we)
        case (A)
          5'd0: {loop_en, play} <= DIN[1:0];
          5'd1: start[ADDR_W-2:15] <= DIN[ADDR_W-17:0];
          5'd2: start[14:7] <= DIN[7:0];
          5'd3: start[6:0] <= DIN[7:1];
          5'd7: fend[ADDR_W-2:15] <= DIN[ADDR_W-17:0];
          5'd8: fend[14:7] <= DIN[7:0];
          5'd9: fend[6:0] <= DIN[7:1];
          default: ;
        endcase
    end
  end
`ifdef STE_SND_FRAME_IRQ_EN
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) SINT <= 1'b0;
    else SINT <= frame_end;
  end
`else
  assign SINT = 1'b0;
`endif
endmodule

// File: tb/tb_ste_snd_dma.sv
// tb_ste_snd_dma: randomized checks of ste_snd_dma against a frame-level fetch-address model
module tb_ste_snd_dma;
  localparam int ADDR_W = 22;
  localparam int LOAD_LEN = 4;
`ifdef STE_SND_FRAME_IRQ_EN
  localparam int IRQ = 1;
`else
  localparam int IRQ = 0;
`endif
  logic clk32 = 1'b0, resb = 1'b0, CS = 1'b0, RW = 1'b1, SREQ = 1'b1, SND_SLOT = 1'b0;
  logic [4:0] A = '0;
  logic [15:0] DIN = '0, DOUT;
  logic SLOAD_N, SACTIVE, SINT;
  logic [ADDR_W-2:0] SADDR;
  int checks = 0, errors = 0;
  logic [20:0] addr_q[$], exp_q[$];
  int len_q[$];
  int nsint = 0, nact = 0, run = 0, slot_per = 64, slot_cnt = 0;
  bit slot_en = 1'b0;
  logic prev_sl = 1'b1;

  ste_snd_dma #(.ADDR_W(ADDR_W), .LOAD_LEN(LOAD_LEN)) dut (
    .clk32(clk32), .resb(resb), .CS(CS), .A(A), .RW(RW), .DIN(DIN), .DOUT(DOUT),
    .SREQ(SREQ), .SND_SLOT(SND_SLOT), .SLOAD_N(SLOAD_N), .SADDR(SADDR),
    .SACTIVE(SACTIVE), .SINT(SINT));

  always #5 clk32 = ~clk32;

  initial forever begin
    @(negedge clk32);
    slot_cnt++;
    SND_SLOT = slot_en && (slot_cnt % slot_per == 0);
  end

  initial forever begin
    @(negedge clk32);
    if (prev_sl && !SLOAD_N) addr_q.push_back(SADDR);
    if (!SLOAD_N) run++;
    if (!prev_sl && SLOAD_N) begin
      len_q.push_back(run);
      run = 0;
    end
    if (SINT) nsint++;
    if (SACTIVE) nact++;
    prev_sl = SLOAD_N;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b0; A = a; DIN = {8'($urandom), d};
    @(negedge clk32);
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b1; A = a;
    #1 d = DOUT;
    @(negedge clk32);
    CS = 1'b0;
  endtask

  task automatic rd_cnt(output logic [23:0] v);
    logic [15:0] h, m, l;
    rd(5'd4, h); rd(5'd5, m); rd(5'd6, l);
    v = {h[7:0], m[7:0], l[7:0]};
  endtask

  task automatic set_frame(input logic [23:0] sb, input logic [23:0] eb);
    wr(5'd1, sb[23:16]); wr(5'd2, sb[15:8]); wr(5'd3, sb[7:0]);
    wr(5'd7, eb[23:16]); wr(5'd8, eb[15:8]); wr(5'd9, eb[7:0]);
  endtask

  task automatic clr_mon();
    addr_q.delete(); len_q.delete(); exp_q.delete();
    nsint = 0; nact = 0;
  endtask

  task automatic wait_idle(output bit ok);
    int b;
    b = 20000;
    @(negedge clk32);
    while (SACTIVE && b > 0) begin
      @(negedge clk32);
      b--;
    end
    ok = !SACTIVE;
    repeat (3) @(negedge clk32);
  endtask

  task automatic wait_fetches(input int n, output bit ok);
    int b;
    b = 20000;
    while (addr_q.size() < n && b > 0) begin
      @(negedge clk32);
      b--;
    end
    ok = addr_q.size() >= n;
  endtask

  // Expected word addresses of one frame: start up to (not including) end, modulo 2^21
  function automatic void add_frame(input logic [20:0] s, input logic [20:0] e);
    for (logic [20:0] a = s; a != e; a++) exp_q.push_back(a);
  endfunction

  task automatic test_reset();
    logic [15:0] d;
    checks++;
    if (SLOAD_N !== 1'b1 || SACTIVE !== 1'b0 || SINT !== 1'b0 || SADDR !== '0) begin
      errors++;
      $display("FAIL reset_outputs got SLOAD_N=%b SACTIVE=%b SINT=%b SADDR=%h need 1 0 0 0", SLOAD_N, SACTIVE, SINT, SADDR);
    end
    for (int i = 0; i < 10; i++) begin
      rd(5'(i), d);
      checks++;
      if (d !== 16'h0) begin errors++; $display("FAIL reset_reg%0d got %h need 0000", i, d); end
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [15:0] d;
    logic [23:0] c;
    slot_per = 64;
    clr_mon();
    set_frame(24'h010000, 24'h010008);
    add_frame(21'h8000, 21'h8004);
    wr(5'd0, 8'h01);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout SACTIVE stuck got 1 need 0"); end
    checks++;
    if (addr_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count got %0d need %0d", addr_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_addr%0d got %h need %h", i, i < addr_q.size() ? addr_q[i] : 21'hx, exp_q[i]); end
    end
    foreach (len_q[i]) begin
      checks++;
      if (len_q[i] != LOAD_LEN) begin errors++; $display("FAIL single_len%0d got %0d need %0d", i, len_q[i], LOAD_LEN); end
    end
    checks++;
    if (nsint != IRQ) begin errors++; $display("FAIL single_sint got %0d need %0d", nsint, IRQ); end
    rd(5'd0, d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL single_ctrl got %h need 0000", d); end
    rd_cnt(c);
    checks++;
    if (c !== 24'h010008) begin errors++; $display("FAIL single_counter got %h need 010008", c); end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [20:0] s, e;
    logic [23:0] c;
    for (int it = 0; it < 4; it++) begin
      s = (it == 0) ? 21'h1FFFFE : 21'($urandom);
      e = s + 21'($urandom_range(1, 5));
      slot_per = $urandom_range(12, 40);
      clr_mon();
      set_frame({2'b00, s, 1'b0}, {2'b00, e, 1'b0});
      add_frame(s, e);
      wr(5'd0, 8'h01);
      wait_idle(ok);
      checks++;
      if (!ok || addr_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d need %0d (idle=%0d)", it, addr_q.size(), exp_q.size(), ok); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_addr%0d got %h need %h", it, i, i < addr_q.size() ? addr_q[i] : 21'hx, exp_q[i]); end
      end
      foreach (len_q[i]) begin
        checks++;
        if (len_q[i] != LOAD_LEN) begin errors++; $display("FAIL rand%0d_len got %0d need %0d", it, len_q[i], LOAD_LEN); end
      end
      checks++;
      if (nsint != IRQ) begin errors++; $display("FAIL rand%0d_sint got %0d need %0d", it, nsint, IRQ); end
      rd_cnt(c);
      checks++;
      if (c !== {2'b00, e, 1'b0}) begin errors++; $display("FAIL rand%0d_counter got %h need %h", it, c, {2'b00, e, 1'b0}); end
    end
  endtask

  task automatic test_loop();
    bit ok;
    slot_per = $urandom_range(16, 40);
    clr_mon();
    set_frame(24'h010000, 24'h010008);
    add_frame(21'h8000, 21'h8004);
    add_frame(21'h8000, 21'h8002);
    add_frame(21'h8000, 21'h8002);
    wr(5'd0, 8'h03);
    wait_fetches(1, ok);
    wr(5'd9, 8'h04);
    wait_fetches(7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL loop_progress got %0d fetches need 7", addr_q.size()); end
    wr(5'd0, 8'h01);
    wait_idle(ok);
    checks++;
    if (!ok || addr_q.size() != exp_q.size()) begin errors++; $display("FAIL loop_count got %0d need %0d (idle=%0d)", addr_q.size(), exp_q.size(), ok); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL loop_addr%0d got %h need %h", i, i < addr_q.size() ? addr_q[i] : 21'hx, exp_q[i]); end
    end
    checks++;
    if (nsint != 3 * IRQ) begin errors++; $display("FAIL loop_sint got %0d need %0d", nsint, 3 * IRQ); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n0, lows;
    slot_per = 32;
    clr_mon();
    set_frame(24'h030000, 24'h030010);
    add_frame(21'h18000, 21'h18008);
    wr(5'd0, 8'h01);
    wait_fetches(3, ok);
    SREQ = 1'b0;
    repeat (LOAD_LEN + 2) @(negedge clk32);
    n0 = addr_q.size();
    lows = 0;
    repeat (500) begin
      @(negedge clk32);
      if (!SLOAD_N) lows++;
    end
    checks++;
    if (addr_q.size() != n0 || lows != 0) begin errors++; $display("FAIL bp_stall got %0d new fetches %0d low cycles need 0 0", addr_q.size() - n0, lows); end
    SREQ = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok || addr_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d need %0d (idle=%0d)", addr_q.size(), exp_q.size(), ok); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_addr%0d got %h need %h", i, i < addr_q.size() ? addr_q[i] : 21'hx, exp_q[i]); end
    end
  endtask

  task automatic test_empty_frame();
    bit ok;
    logic [23:0] c;
    slot_per = 8;
    clr_mon();
    set_frame(24'h020000, 24'h020000);
    wr(5'd0, 8'h01);
    wait_idle(ok);
    checks++;
    if (!ok || addr_q.size() != 0) begin errors++; $display("FAIL empty_fetch got %0d need 0 (idle=%0d)", addr_q.size(), ok); end
    checks++;
    if (nsint != IRQ) begin errors++; $display("FAIL empty_sint got %0d need %0d", nsint, IRQ); end
    checks++;
    if (nact < 1 || nact > 2) begin errors++; $display("FAIL empty_active got %0d cycles need 1..2", nact); end
    rd_cnt(c);
    checks++;
    if (c !== 24'h020000) begin errors++; $display("FAIL empty_counter got %h need 020000", c); end
  endtask

  task automatic test_reset_mid();
    int b;
    logic [15:0] d;
    slot_per = 16;
    set_frame(24'h010000, 24'h010008);
    wr(5'd0, 8'h03);
    b = 2000;
    while (SLOAD_N && b > 0) begin
      @(negedge clk32);
      b--;
    end
    checks++;
    if (SLOAD_N !== 1'b0) begin errors++; $display("FAIL rstmid_start got SLOAD_N=%b need 0", SLOAD_N); end
    #2 resb = 1'b0;
    #1;
    checks++;
    if (SLOAD_N !== 1'b1 || SACTIVE !== 1'b0) begin errors++; $display("FAIL rstmid_async got SLOAD_N=%b SACTIVE=%b need 1 0", SLOAD_N, SACTIVE); end
    @(negedge clk32);
    resb = 1'b1;
    clr_mon();
    for (int i = 0; i < 10; i++) begin
      rd(5'(i), d);
      checks++;
      if (d !== 16'h0) begin errors++; $display("FAIL rstmid_reg%0d got %h need 0000", i, d); end
    end
    repeat (300) @(negedge clk32);
    checks++;
    if (addr_q.size() != 0 || SACTIVE !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %0d fetches SACTIVE=%b need 0 0", addr_q.size(), SACTIVE); end
  endtask

  initial begin
    #23 resb = 1'b1;
    @(negedge clk32);
    test_reset();
    slot_en = 1'b1;
    test_single_frame();
    test_random_frames();
    test_loop();
    test_backpressure();
    test_empty_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
